// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register. Sits directly
//   downstream of the pc unit: it forwards the current PC to a synchronous
//   instruction memory (1-cycle read latency), returns PC+4 to the pc unit,
//   and holds the instruction in ID across stalls and squashes it on flush.
//
// Ports
//   clk          in   1      clock, all state updates on rising edge
//   rst          in   1      synchronous reset, active-high
//   pc           in   XLEN   current PC from the pc unit
//   if_id_write  in   1      1 = IF/ID advances, 0 = stall/hold
//   if_flush     in   1      1 = squash the instruction entering ID
//   imem_rdata   in   XLEN   instruction memory data, valid 1 cycle after addr
//   imem_addr    out  XLEN   instruction memory address (= pc)
//   pc_4_if      out  XLEN   pc + 4, combinational, to pc unit
//   pc_plus4_id  out  XLEN   registered PC+4 of the instruction in ID
//   pc_4_id      out  4      upper four bits of pc_plus4_id (jump path)
//   offset28     out  28     {instr_id[25:0], 2'b00} (jump path)
//   instr_id     out  XLEN   instruction in ID (NOP when slot invalid)
//   valid_id     out  1      ID slot holds a real instruction
//   fetch_cnt    out  CNT_W  number of valid instructions accepted into ID
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int              XLEN  = 32,
  parameter logic [XLEN-1:0] NOP   = {XLEN{1'b0}},
  parameter int              CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc,
  input  logic             if_id_write,
  input  logic             if_flush,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  pc_4_if,
  output logic [XLEN-1:0]  pc_plus4_id,
  output logic [3:0]       pc_4_id,
  output logic [27:0]      offset28,
  output logic [XLEN-1:0]  instr_id,
  output logic             valid_id,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [XLEN-1:0]  PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] CNT_STEP = {{(CNT_W-1){1'b0}}, 1'b1};

  // Copy of the ID instruction captured on the first stall edge. The memory
  // keeps re-reading while the PC is held, so its output cannot be trusted
  // to still show the stalled instruction.
  logic [XLEN-1:0] hold_reg;
  logic            use_hold;

  // Memory address and next sequential PC are pure functions of pc.
  always_comb begin
    imem_addr = pc;
    pc_4_if   = pc + PC_STEP;
  end

  // IF/ID register: priority rst > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_plus4_id <= {XLEN{1'b0}};
      valid_id    <= 1'b0;
      use_hold    <= 1'b0;
      hold_reg    <= {XLEN{1'b0}};
      fetch_cnt   <= {CNT_W{1'b0}};
    end else if (if_flush) begin
      // Bubble: PC+4 still tracks the squashed slot, counter untouched.
      pc_plus4_id <= pc_4_if;
      valid_id    <= 1'b0;
      use_hold    <= 1'b0;
    end else if (!if_id_write) begin
      // Capture only on the first stall edge; later edges would grab the
      // re-read data instead of the instruction actually in ID.
      if (!use_hold) begin
        hold_reg <= imem_rdata;
        use_hold <= 1'b1;
      end else begin
        hold_reg <= hold_reg;
        use_hold <= use_hold;
      end
    end else begin
      pc_plus4_id <= pc_4_if;
      valid_id    <= 1'b1;
      use_hold    <= 1'b0;
      fetch_cnt   <= fetch_cnt + CNT_STEP;
    end
  end

  // ID instruction select; the memory output is used directly except while
  // a stall is being held.
  always_comb begin
    if (!valid_id) begin
      instr_id = NOP;
    end else if (use_hold) begin
      instr_id = hold_reg;
    end else begin
      instr_id = imem_rdata;
    end
  end

  // Jump-path fields for the pc unit.
  always_comb begin
    offset28 = {instr_id[25:0], 2'b00};
    pc_4_id  = pc_plus4_id[XLEN-1:XLEN-4];
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A small synchronous memory model
//   feeds imem_rdata; each driven cycle pushes the architecturally expected
//   ID state into a scoreboard queue, which the scenario tasks pop and compare
//   one cycle later.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        if_id_write;
  logic        if_flush;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc_4_if;
  logic [31:0] pc_plus4_id;
  logic [3:0]  pc_4_id;
  logic [27:0] offset28;
  logic [31:0] instr_id;
  logic        valid_id;
  logic [31:0] fetch_cnt;

  fetch_stage #(.XLEN(32), .NOP(32'h0000_0000), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .if_id_write (if_id_write),
    .if_flush    (if_flush),
    .imem_rdata  (imem_rdata),
    .imem_addr   (imem_addr),
    .pc_4_if     (pc_4_if),
    .pc_plus4_id (pc_plus4_id),
    .pc_4_id     (pc_4_id),
    .offset28    (offset28),
    .instr_id    (instr_id),
    .valid_id    (valid_id),
    .fetch_cnt   (fetch_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total;
  int          bad;
  logic        corrupt;      // memory returns 0xDEADBEEF while set
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic [31:0] m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_fn = 32'h2008_0001;
      32'h0000_0004: mem_fn = 32'h2009_0002;
      32'h0000_0008: mem_fn = 32'h012A_5020;
      32'h0000_0010: mem_fn = 32'h8D28_0000;
      32'h0000_0014: mem_fn = 32'h0109_5820;
      32'h0000_003C: mem_fn = 32'h1000_0003;
      32'h0000_0044: mem_fn = 32'h2010_0044;
      32'hF000_0000: mem_fn = 32'h0800_0001;
      default:       mem_fn = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) begin
    imem_rdata <= corrupt ? 32'hDEAD_BEEF : mem_fn(imem_addr);
  end

  // Drive one cycle, push the expected post-edge ID state, step past the edge.
  task automatic drive(input logic r, input logic [31:0] p, input logic wr,
                       input logic fl);
    rst = r; pc = p; if_id_write = wr; if_flush = fl;
    if (r) begin
      m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    end else if (fl) begin
      m_valid = 1'b0; m_instr = 32'h0; m_pc4 = p + 32'd4;
    end else if (wr) begin
      m_valid = 1'b1; m_pc4 = p + 32'd4; m_cnt = m_cnt + 32'd1;
      m_instr = corrupt ? 32'hDEAD_BEEF : mem_fn(p);
    end else begin
      m_valid = m_valid;   // stall: ID contents unchanged
    end
    sb.push_back({m_valid, m_instr, m_pc4, m_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) drive(1'b1, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      total++;
      if ({valid_id, instr_id, pc_plus4_id, fetch_cnt} !== {e.valid, e.instr, e.pc4, e.cnt}) begin
        bad++;
        $display("FAIL reset_state: got v=%0b i=%h p=%h c=%0d want v=%0b i=%h p=%h c=%0d",
                 valid_id, instr_id, pc_plus4_id, fetch_cnt, e.valid, e.instr, e.pc4, e.cnt);
      end
    end
    total++;
    if (pc_4_if !== 32'h4) begin
      bad++;
      $display("FAIL reset_pc_4_if: got %h want 00000004", pc_4_if);
    end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'(i * 4), 1'b1, 1'b0);
      e = sb.pop_front();
      total++;
      if ({valid_id, instr_id, pc_plus4_id, fetch_cnt} !== {e.valid, e.instr, e.pc4, e.cnt}) begin
        bad++;
        $display("FAIL stream_%0d: got v=%0b i=%h p=%h c=%0d want v=%0b i=%h p=%h c=%0d", i,
                 valid_id, instr_id, pc_plus4_id, fetch_cnt, e.valid, e.instr, e.pc4, e.cnt);
      end
    end
  endtask

  task automatic test_stall();
    drive(1'b0, 32'h10, 1'b1, 1'b0);
    void'(sb.pop_front());
    total++;
    if (instr_id !== 32'h8D28_0000) begin
      bad++;
      $display("FAIL stall_setup: got %h want 8d280000", instr_id);
    end
    corrupt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h14, 1'b0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({instr_id, pc_plus4_id, fetch_cnt} !== {e.instr, e.pc4, e.cnt}) begin
        bad++;
        $display("FAIL stall_hold_%0d: got i=%h p=%h c=%0d want i=%h p=%h c=%0d", i,
                 instr_id, pc_plus4_id, fetch_cnt, e.instr, e.pc4, e.cnt);
      end
    end
    corrupt = 1'b0;
    drive(1'b0, 32'h14, 1'b1, 1'b0);
    e = sb.pop_front();
    total++;
    if ({valid_id, instr_id, pc_plus4_id, fetch_cnt} !== {e.valid, e.instr, e.pc4, e.cnt}) begin
      bad++;
      $display("FAIL stall_release: got v=%0b i=%h p=%h c=%0d want v=%0b i=%h p=%h c=%0d",
               valid_id, instr_id, pc_plus4_id, fetch_cnt, e.valid, e.instr, e.pc4, e.cnt);
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 32'h3C, 1'b1, 1'b0);
    drive(1'b0, 32'h40, 1'b1, 1'b1);
    drive(1'b0, 32'h44, 1'b1, 1'b0);
    void'(sb.pop_front());
    // Check the bubble cycle by replaying its expectation against history:
    // compare the final (resumed) state here, bubble checked in test_flush_bubble.
    e = sb.pop_front();
    e = sb.pop_front();
    total++;
    if ({valid_id, instr_id, pc_plus4_id, fetch_cnt} !== {e.valid, e.instr, e.pc4, e.cnt}) begin
      bad++;
      $display("FAIL flush_resume: got v=%0b i=%h p=%h c=%0d want v=%0b i=%h p=%h c=%0d",
               valid_id, instr_id, pc_plus4_id, fetch_cnt, e.valid, e.instr, e.pc4, e.cnt);
    end
  endtask

  task automatic test_flush_bubble();
    drive(1'b0, 32'h3C, 1'b1, 1'b0);
    void'(sb.pop_front());
    drive(1'b0, 32'h40, 1'b1, 1'b1);
    e = sb.pop_front();
    total++;
    if ({valid_id, instr_id, offset28, pc_plus4_id, fetch_cnt} !==
        {e.valid, e.instr, e.instr[25:0], 2'b00, e.pc4, e.cnt}) begin
      bad++;
      $display("FAIL flush_bubble: got v=%0b i=%h o=%h p=%h c=%0d want v=%0b i=%h p=%h c=%0d",
               valid_id, instr_id, offset28, pc_plus4_id, fetch_cnt, e.valid, e.instr, e.pc4, e.cnt);
    end
  endtask

  task automatic test_jump_fields();
    drive(1'b0, 32'hF000_0000, 1'b1, 1'b0);
    void'(sb.pop_front());
    total++;
    if ({offset28, pc_4_id} !== {28'h000_0004, 4'hF}) begin
      bad++;
      $display("FAIL jump_fields: got o=%h u=%h want o=0000004 u=f", offset28, pc_4_id);
    end
  endtask

  task automatic test_corners();
    // Reset arriving in the middle of a stall.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    corrupt = 1'b1;
    drive(1'b0, 32'h4, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    corrupt = 1'b0;
    void'(sb.pop_front());
    void'(sb.pop_front());
    e = sb.pop_front();
    total++;
    if ({valid_id, instr_id, fetch_cnt} !== {e.valid, e.instr, e.cnt}) begin
      bad++;
      $display("FAIL reset_in_stall: got v=%0b i=%h c=%0d want v=%0b i=%h c=%0d",
               valid_id, instr_id, fetch_cnt, e.valid, e.instr, e.cnt);
    end
    // Flush together with stall: flush wins, then a stall keeps the bubble.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    void'(sb.pop_front());
    drive(1'b0, 32'h80, 1'b0, 1'b1);
    e = sb.pop_front();
    total++;
    if ({valid_id, instr_id, pc_plus4_id, fetch_cnt} !== {e.valid, e.instr, e.pc4, e.cnt}) begin
      bad++;
      $display("FAIL flush_over_stall: got v=%0b i=%h p=%h c=%0d want v=%0b i=%h p=%h c=%0d",
               valid_id, instr_id, pc_plus4_id, fetch_cnt, e.valid, e.instr, e.pc4, e.cnt);
    end
    drive(1'b0, 32'h84, 1'b0, 1'b0);
    e = sb.pop_front();
    total++;
    if ({valid_id, instr_id, pc_plus4_id} !== {e.valid, e.instr, e.pc4}) begin
      bad++;
      $display("FAIL stall_after_flush: got v=%0b i=%h p=%h want v=%0b i=%h p=%h",
               valid_id, instr_id, pc_plus4_id, e.valid, e.instr, e.pc4);
    end
    // PC wrap on the combinational adder.
    pc = 32'hFFFF_FFFC;
    #1;
    total++;
    if ({imem_addr, pc_4_if} !== {32'hFFFF_FFFC, 32'h0000_0000}) begin
      bad++;
      $display("FAIL pc_wrap: got a=%h p4=%h want a=fffffffc p4=00000000", imem_addr, pc_4_if);
    end
  endtask

  initial begin
    total = 0; bad = 0; corrupt = 1'b0;
    m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    rst = 1'b1; pc = 32'h0; if_id_write = 1'b0; if_flush = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_bubble();
    test_flush();
    test_jump_fields();
    test_corners();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
